// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: op encodings, FSM state constants and decode helpers.
// Imported by the MDU datapath and by anything that decodes MDU instructions.
`timescale 1ns/1ps
package mdu_unit_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_MADD  = 4'd2;
  localparam logic [3:0] MDU_MADDU = 4'd3;
  localparam logic [3:0] MDU_DIV   = 4'd4;
  localparam logic [3:0] MDU_DIVU  = 4'd5;
  localparam logic [3:0] MDU_MTHI  = 4'd6;
  localparam logic [3:0] MDU_MTLO  = 4'd7;
  localparam logic [3:0] MDU_MFHI  = 4'd8;
  localparam logic [3:0] MDU_MFLO  = 4'd9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Any op the hazard unit must treat as touching HI/LO.
  function automatic logic is_mdu_op(input logic [3:0] op);
    return op <= MDU_MFLO;
  endfunction

  function automatic logic is_multicycle(input logic [3:0] op);
    return op <= MDU_DIVU;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: full {hi,lo} outcome of a multi-cycle MDU op,
// including the divide-by-zero and signed-overflow conventions.
`timescale 1ns/1ps
module mdu_calc
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo
);

  localparam int DW = 2 * WIDTH;

  logic [DW-1:0]           s_prod;
  logic [DW-1:0]           u_prod;
  logic [DW-1:0]           res;
  logic signed [WIDTH-1:0] s_quo;
  logic signed [WIDTH-1:0] s_rem;
  logic [WIDTH-1:0]        u_quo;
  logic [WIDTH-1:0]        u_rem;
  logic                    div_zero;
  logic                    div_ovf;

  // Operands are extended to full product width so the multiply wraps mod 2^DW.
  assign s_prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign u_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign s_quo = $signed(a) / $signed(b);
  assign s_rem = $signed(a) % $signed(b);
  assign u_quo = a / b;
  assign u_rem = a % b;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res = {hi, lo};
    case (op)
      MDU_MULT:  res = s_prod;
      MDU_MULTU: res = u_prod;
      MDU_MADD:  res = {hi, lo} + s_prod;
      MDU_MADDU: res = {hi, lo} + u_prod;
      MDU_DIV: begin
        if (div_zero)     res = {a, {WIDTH{1'b1}}};
        else if (div_ovf) res = {{WIDTH{1'b0}}, a};
        else              res = {s_rem, s_quo};
      end
      MDU_DIVU: begin
        if (div_zero) res = {a, {WIDTH{1'b1}}};
        else          res = {u_rem, u_quo};
      end
      default: res = {hi, lo};
    endcase
  end

  assign p_hi = res[DW-1:WIDTH];
  assign p_lo = res[WIDTH-1:0];

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO: fixed-latency busy counter,
// atomic HI/LO commit, single-cycle MTHI/MTLO and a stall request for hazards.
`timescale 1ns/1ps
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall_req
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;
  logic [3:0]       op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic [WIDTH-1:0] p_hi,    p_lo;
  logic             idle;

  // HI/LO cannot change while busy, so the live registers are the launch snapshot.
  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi   (hi_q),
    .lo   (lo_q),
    .p_hi (p_hi),
    .p_lo (p_lo)
  );

  assign idle = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_multicycle(op)) begin
          state_d = ST_BUSY;
          op_d    = op;
          a_d     = A;
          b_d     = B;
          cnt_d   = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end else if (start && (op == MDU_MTHI)) begin
          hi_d = A;
        end else if (start && (op == MDU_MTLO)) begin
          lo_d = A;
        end
      end
      default: begin
        // Last busy cycle: commit both halves together.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = p_hi;
          lo_d    = p_lo;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = !idle;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = busy | (start & is_mdu_op(op));

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, multi-cycle corner
// sequences, then randomized ops checked against a 64-bit arithmetic model.
`timescale 1ns/1ps
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         stall_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mdu_unit #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: architectural effect of one op on HI/LO, in 64-bit arithmetic.
  function automatic void model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, acc;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    ua  = {32'b0, ma};
    ub  = {32'b0, mb};
    acc = {m_hi, m_lo};
    case (mop)
      MDU_MULT:  {m_hi, m_lo} = sa * sb;
      MDU_MULTU: {m_hi, m_lo} = ua * ub;
      MDU_MADD:  {m_hi, m_lo} = acc + longint'(sa * sb);
      MDU_MADDU: {m_hi, m_lo} = acc + ua * ub;
      MDU_DIV, MDU_DIVU: begin
        if (mb == 0) begin
          m_lo = '1;
          m_hi = ma;
        end else if (mop == MDU_DIV) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = 32'(q);
          m_hi = 32'(r);
        end else begin
          m_lo = 32'(ua / ub);
          m_hi = 32'(ua % ub);
        end
      end
      MDU_MTHI: m_hi = ma;
      MDU_MTLO: m_lo = ma;
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is expected high.
  task automatic do_op(input logic [3:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                       input string name, input bit intrude);
    int n, stall_bad, done_bad, exp_n;
    exp_n = is_div(op_i) ? DC : MC;
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    #1;
    check({name, ".stall_at_start"}, 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0; stall_bad = 0; done_bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (!stall_req) stall_bad++;
      if (done) done_bad++;
      if (intrude && n == 2) begin
        start = 1'b1; op = MDU_MULT; a = $urandom; b = $urandom;
      end else if (intrude && n == 3) begin
        op = MDU_MTLO; a = 32'hdead_beef;
      end else if (intrude && n == 4) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, ".busy_cycles"}, 64'(n), 64'(exp_n));
    check({name, ".stall_while_busy"}, 64'(stall_bad), 64'd0);
    check({name, ".done_while_busy"}, 64'(done_bad), 64'd0);
    check({name, ".done_pulse"}, 64'(done), 64'd1);
    check({name, ".hi"}, 64'(hi), 64'(exp_hi));
    check({name, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  // Single-cycle op (MTHI/MTLO/MF*/non-MDU), called at a negedge.
  task automatic do_single(input logic [3:0] op_i, input logic [W-1:0] a_i,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input string name);
    start = 1'b1; op = op_i; a = a_i; b = $urandom;
    #1;
    check({name, ".stall_req"}, 64'(stall_req), 64'(op_i <= 4'd9));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, ".busy"}, 64'(busy), 64'd0);
    check({name, ".done"}, 64'(done), 64'd0);
    check({name, ".hi"}, 64'(hi), 64'(exp_hi));
    check({name, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int late_done;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    vecs.push_back('{MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{MDU_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA});
    vecs.push_back('{MDU_MADDU, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFB});
    vecs.push_back('{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{MDU_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF});
    vecs.push_back('{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{MDU_MADD,  32'h0000_0002, 32'hFFFF_FFFD, 32'h0000_0000, 32'h7FFF_FFFA});
    vecs.push_back('{MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
    vecs.push_back('{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{MDU_MTHI,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000});
    vecs.push_back('{MDU_MTLO,  32'h0000_5678, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678});
    vecs.push_back('{MDU_MADDU, 32'h0000_0001, 32'h0000_0001, 32'h0000_1234, 32'h0000_5679});
    vecs.push_back('{MDU_MFHI,  32'h0000_9999, 32'h0000_0000, 32'h0000_1234, 32'h0000_5679});

    // Consecutive rows launch in the done cycle of the previous op (back-to-back).
    foreach (vecs[i]) begin
      model(vecs[i].op, vecs[i].a, vecs[i].b);
      if (is_multicycle(vecs[i].op))
        do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i), 1'b0);
      else
        do_single(vecs[i].op, vecs[i].a, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
    end

    // Start and MTLO while busy must both be ignored.
    model(MDU_MULT, 32'd9, 32'hFFFF_FFF9);
    do_op(MDU_MULT, 32'd9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFC1, "intrude", 1'b1);
    @(negedge clk);
    check("intrude.no_relaunch", 64'(busy), 64'd0);

    do_single(4'hF, 32'h1111_1111, m_hi, m_lo, "non_mdu_op");

    // Reset during busy cycle 3 of a DIV.
    start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.hi", 64'(hi), 64'd0);
    check("rst_mid.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    late_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("rst_mid.no_commit", 64'(late_done), 64'd0);
    check("rst_mid.hi_after", 64'(hi), 64'd0);
    model(MDU_MULT, 32'd6, 32'd7);
    do_op(MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "post_rst_mult", 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 9));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 15) == 0) begin
        ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      model(rop, ra, rb);
      if (is_multicycle(rop))
        do_op(rop, ra, rb, m_hi, m_lo, $sformatf("rand%0d", i), 1'b0);
      else
        do_single(rop, ra, m_hi, m_lo, $sformatf("rand%0d", i));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
